// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - RV32I load/store funct3 encodings
//   - FSM state encoding (lsu_state_t)
//   - helpers for request legality, store byte-lane mask and store data
//     lane replication
// ---------------------------------------------------------------------------
package lsu_pkg;

    // RV32I funct3 encodings for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access sequencing states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_LOAD_WAIT = 2'd2,
        ST_RESP      = 2'd3
    } lsu_state_t;

    // Byte-lane write enables for a store of the given size at byte offset
    // off. Unknown sizes give no lanes so nothing can be written by accident.
    function automatic logic [3:0] lane_mask(input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [3:0] m;
        case (f3)
            F3_B:    m = 4'b0001 << off;
            F3_H:    m = off[1] ? 4'b1100 : 4'b0011;
            F3_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Store data replicated across all lanes it may land on, so the mask
    // alone selects which bytes the memory commits.
    function automatic logic [31:0] lane_data(input logic [2:0]  f3,
                                              input logic [31:0] wdata);
        logic [31:0] d;
        case (f3)
            F3_B:    d = {4{wdata[7:0]}};
            F3_H:    d = {2{wdata[15:0]}};
            F3_W:    d = wdata;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    // 1 when the request may be issued to memory: funct3 is valid for the
    // direction and the address is naturally aligned for the access size.
    function automatic logic req_legal(input logic       we,
                                       input logic [2:0] f3,
                                       input logic [1:0] off);
        logic f3_ok;
        logic align_ok;
        if (we) begin
            f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        end
        // f3[1:0] encodes size for every legal code: 00 byte, 01 half, 10 word
        case (f3[1:0])
            2'b01:   align_ok = (off[0] == 1'b0);
            2'b10:   align_ok = (off == 2'b00);
            default: align_ok = 1'b1;
        endcase
        return f3_ok && align_ok;
    endfunction

endpackage

// File: rtl/load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Purely combinational load data aligner. Shifts the raw memory word so the
// addressed byte/halfword sits in the low bits, then sign- or zero-extends
// according to funct3.
// Ports:
//   raw_word_i  32  word as returned by the memory
//   offset_i     2  byte offset of the access within the word
//   funct3_i     3  load funct3 (LB/LH/LW/LBU/LHU)
//   result_o    32  aligned, extended load result (0 for unknown funct3)
// ---------------------------------------------------------------------------
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] raw_word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted_s;

    // Move the addressed bytes down to lane 0
    assign shifted_s = raw_word_i >> {offset_i, 3'b000};

    // Extend the selected field according to the load type
    always_comb begin
        result_o = 32'h0000_0000;
        case (funct3_i)
            F3_B:    result_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_H:    result_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_W:    result_o = shifted_s;
            F3_BU:   result_o = {24'h00_0000, shifted_s[7:0]};
            F3_HU:   result_o = {16'h0000, shifted_s[15:0]};
            default: result_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Core-side initiator for a single-port synchronous data memory with
// one-cycle read latency. Accepts one RV32I load/store per handshake, checks
// legality, issues a single registered memory cycle and returns a one-cycle
// response pulse.
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only when idle)
//   req_we, req_funct3    direction and access type
//   req_addr, req_wdata   byte address and store data
//   resp_valid            one-cycle completion pulse
//   resp_rdata            load result (0 for stores and errors)
//   resp_error            misaligned/illegal request, qualified by resp_valid
//   mem_request           memory strobe, high only during the issue cycle
//   mem_we_re             1 write / 0 read
//   mem_address           word address (byte address bits [ADDR_W+1:2])
//   mem_data_in           lane-replicated store data
//   mem_mask              byte-lane write enables
//   mem_data_out          memory read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic              mem_request,
    output logic              mem_we_re,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    output logic [3:0]        mem_mask,
    input  logic [31:0]       mem_data_out
);

    lsu_state_t        state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_error_q, resp_error_d;
    logic              mem_request_q, mem_request_d;
    logic              mem_we_re_q, mem_we_re_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [31:0]       mem_data_in_q, mem_data_in_d;
    logic [3:0]        mem_mask_q, mem_mask_d;

    logic [31:0]       load_result_s;
    logic              legal_s;
    // Upper address bits beyond the memory size are deliberately dropped so
    // accesses wrap; fold them here to mark them as intentionally unused.
    logic              unused_addr_s;

    assign unused_addr_s = ^{1'b0, req_addr[31:ADDR_W+2]};
    assign legal_s       = req_legal(req_we, req_funct3, req_addr[1:0]);

    load_align u_load_align (
        .raw_word_i (mem_data_out),
        .offset_i   (off_q),
        .funct3_i   (f3_q),
        .result_o   (load_result_s)
    );

    // Next-state and next-output logic for the access sequencer
    always_comb begin
        state_d       = state_q;
        f3_d          = f3_q;
        off_d         = off_q;
        resp_valid_d  = resp_valid_q;
        resp_rdata_d  = resp_rdata_q;
        resp_error_d  = resp_error_q;
        mem_request_d = mem_request_q;
        mem_we_re_d   = mem_we_re_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        mem_mask_d    = mem_mask_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    f3_d  = req_funct3;
                    off_d = req_addr[1:0];
                    if (legal_s) begin
                        // Memory port values are set up now so they are
                        // registered and stable for the whole issue cycle
                        state_d       = ST_ISSUE;
                        mem_request_d = 1'b1;
                        mem_we_re_d   = req_we;
                        mem_address_d = req_addr[ADDR_W+1:2];
                        if (req_we) begin
                            mem_mask_d    = lane_mask(req_funct3, req_addr[1:0]);
                            mem_data_in_d = lane_data(req_funct3, req_wdata);
                        end else begin
                            mem_mask_d    = 4'b0000;
                            mem_data_in_d = 32'h0000_0000;
                        end
                    end else begin
                        // Illegal requests skip memory entirely
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_rdata_d = 32'h0000_0000;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                mem_request_d = 1'b0;
                mem_we_re_d   = 1'b0;
                mem_address_d = {ADDR_W{1'b0}};
                mem_data_in_d = 32'h0000_0000;
                mem_mask_d    = 4'b0000;
                if (mem_we_re_q) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b0;
                    resp_rdata_d = 32'h0000_0000;
                end else begin
                    state_d = ST_LOAD_WAIT;
                end
            end

            ST_LOAD_WAIT: begin
                // Read data is valid this cycle (one-cycle memory latency)
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_error_d = 1'b0;
                resp_rdata_d = load_result_s;
            end

            ST_RESP: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
                resp_error_d = 1'b0;
                resp_rdata_d = 32'h0000_0000;
            end

            default: begin
                state_d       = ST_IDLE;
                resp_valid_d  = 1'b0;
                resp_error_d  = 1'b0;
                resp_rdata_d  = 32'h0000_0000;
                mem_request_d = 1'b0;
                mem_we_re_d   = 1'b0;
                mem_address_d = {ADDR_W{1'b0}};
                mem_data_in_d = 32'h0000_0000;
                mem_mask_d    = 4'b0000;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            f3_q          <= 3'b000;
            off_q         <= 2'b00;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'h0000_0000;
            resp_error_q  <= 1'b0;
            mem_request_q <= 1'b0;
            mem_we_re_q   <= 1'b0;
            mem_address_q <= {ADDR_W{1'b0}};
            mem_data_in_q <= 32'h0000_0000;
            mem_mask_q    <= 4'b0000;
        end else begin
            state_q       <= state_d;
            f3_q          <= f3_d;
            off_q         <= off_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_error_q  <= resp_error_d;
            mem_request_q <= mem_request_d;
            mem_we_re_q   <= mem_we_re_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            mem_mask_q    <= mem_mask_d;
        end
    end

    // Ready is a direct decode of the state register
    assign req_ready   = (state_q == ST_IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_error  = resp_error_q;
    assign mem_request = mem_request_q;
    assign mem_we_re   = mem_we_re_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_mask    = mem_mask_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the single-port synchronous data memory. Accepts one RV32I load or store per handshake from the execute stage, checks alignment, and converts the byte address into a word address, byte mask and lane-replicated store data. It drives the memory's request/write/address/mask/data-in port, captures the one-cycle-latency read data, and returns an aligned, sign- or zero-extended load result to the core.

## Interface

- `ADDR_W`, default 8: width of the memory word address; the memory holds 2^ADDR_W words.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `req_valid`  in  1: core presents an access.
- `req_ready`  out  1: unit can accept; high only in IDLE.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_funct3`  in  3: RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data (rs2).
- `resp_valid`  out  1: one-cycle pulse, access complete.
- `resp_rdata`  out  32: load result; 0 for stores and errors.
- `resp_error`  out  1: misaligned address or illegal funct3; qualified by `resp_valid`.
- `mem_request`  out  1: memory request strobe.
- `mem_we_re`  out  1: 1 = write, 0 = read.
- `mem_address`  out  ADDR_W: word address.
- `mem_data_in`  out  32: write data to memory.
- `mem_mask`  out  4: byte-lane write enables; lane i is bits [8i+7:8i].
- `mem_data_out`  in  32: read data; valid the cycle after a read request.

## Operation

- FSM states: IDLE, ISSUE, LOAD_WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch the request.
  - Legal request: go to ISSUE.
  - Illegal request: go to RESP with error set.
- Illegal request: any of the following.
  - Halfword access with `req_addr[0]`≠0.
  - Word access with `req_addr[1:0]`≠0.
  - Load funct3 of 011, 110 or 111.
  - Store funct3 of 011 or any value ≥100.
- ISSUE: memory outputs are registered and held for exactly this cycle.
  - `mem_request`=1.
  - `mem_we_re`=`req_we`.
  - `mem_address`=`req_addr[ADDR_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo memory size.
  - Next state: store goes to RESP; load goes to LOAD_WAIT.
- Store lanes:
  - SB: mask=1<<addr[1:0], data={4{wdata[7:0]}}.
  - SH: mask=0011 (addr[1]=0) or 1100, data={2{wdata[15:0]}}.
  - SW: mask=1111, data=wdata.
- Loads: `mem_mask`=0000 and `mem_data_in`=0.
- LOAD_WAIT:
  - Sample `mem_data_out`.
  - Shift right by addr[1:0]×8.
  - Extend: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - Register the result into `resp_rdata`, then go to RESP.
- RESP: `resp_valid`=1 for one cycle, then return to IDLE. There is no response back-pressure; the core must take it.
- `mem_request` is 0 in IDLE, LOAD_WAIT and RESP. At most one access is outstanding.
- Erroring requests never assert `mem_request`.

## Timing

- Handshake at edge N. ISSUE during cycle N+1.
  - Store: `resp_valid` in cycle N+2.
  - Load: `resp_valid` in cycle N+3.
  - Error: `resp_valid` in cycle N+1.
- Next accept is possible in the cycle after RESP. Sustained throughput: one store per 3 cycles, one load per 4 cycles.
- Reset values: state=IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0, `mem_request`=0, `mem_we_re`=0, `mem_address`=0, `mem_data_in`=0, `mem_mask`=0.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronously), the access is abandoned, and no response is produced.
  - A write whose ISSUE cycle is cut by reset before the edge does not commit.
- `req_*` inputs are ignored outside IDLE and need not be held after the handshake.

## Structure

- Package `lsu_pkg` holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the FSM state enum `lsu_state_t`;
  - a `lane_mask` function.
- Sub-module `load_align`: purely combinational. Takes raw word, addr[1:0] and funct3; produces the extended 32-bit result. Instanced once, feeding the LOAD_WAIT capture.

## Test plan

- SW addr 0x0000_0010, wdata 0xDEAD_BEEF → ISSUE: address 4, mask 1111, we 1, data 0xDEADBEEF; `resp_valid` at N+2, error 0.
- SB addr 0x13, wdata 0x0000_00A5, then LW 0x10 → second access gives mask 1000, data 0xA5A5A5A5; word reads 0xA5ADBEEF.
- LB 0x13 → 0xFFFF_FFA5. LBU 0x13 → 0x0000_00A5. LH 0x12 → 0xFFFF_A5AD. Each `resp_valid` at N+3.
- LW 0x0000_0006, then SH 0x0000_0005 → `resp_error`=1 at N+1, `resp_rdata`=0, `mem_request` never asserted.
- Load funct3 011 → error response. SW to byte address 0x400 → `mem_address`=0, showing wrap.
- Assert `rst` during LOAD_WAIT of an LW → `resp_valid` never pulses, `req_ready`=1 immediately, and the next LW completes normally.
